// File: rtl/assoc_pkg.sv
// Shared constants for the associative-memory classifier path: score/index widths,
// class count and the argmax FSM state encoding.
package assoc_pkg;
   localparam int SCORE_W     = 13;
   localparam int NUM_CLASSES = 26;
   localparam int IDX_W       = 5;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;
endpackage

// File: rtl/assoc_top2_tracker.sv
// Combinational best/second-best update for one incoming class score.
// Strict compare against best keeps the lower index on ties.
module assoc_top2_tracker
   import assoc_pkg::*;
#(
   parameter int SCORE_W = assoc_pkg::SCORE_W,
   parameter int IDX_W   = assoc_pkg::IDX_W
) (
   input  logic [SCORE_W-1:0] score_in,
   input  logic [IDX_W-1:0]   cnt,
   input  logic [SCORE_W-1:0] best,
   input  logic [SCORE_W-1:0] second,
   input  logic [IDX_W-1:0]   best_idx,
   output logic [SCORE_W-1:0] best_nxt,
   output logic [SCORE_W-1:0] second_nxt,
   output logic [IDX_W-1:0]   best_idx_nxt
);

   always_comb begin
      best_nxt     = best;
      second_nxt   = second;
      best_idx_nxt = best_idx;
      if (score_in > best) begin
         second_nxt   = best;
         best_nxt     = score_in;
         best_idx_nxt = cnt;
      end else if (score_in > second) begin
         second_nxt = score_in;
      end
   end

endmodule

// File: rtl/assoc_argmax.sv
// Collects one score per class, tracks top-2, and publishes winner index,
// winner score and margin with a one-cycle done pulse.
//
// state   | meaning
// IDLE    | waiting for start; scores here set seq_err
// COLLECT | accepting class scores 0..NUM_CLASSES-1
// DONE    | results just published; back to IDLE next cycle
module assoc_argmax
   import assoc_pkg::*;
#(
   parameter int SCORE_W     = assoc_pkg::SCORE_W,
   parameter int NUM_CLASSES = assoc_pkg::NUM_CLASSES,
   parameter int IDX_W       = assoc_pkg::IDX_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               score_valid,
   input  logic [SCORE_W-1:0] score_in,
   output logic               busy,
   output logic               done,
   output logic [IDX_W-1:0]   winner_idx,
   output logic [SCORE_W-1:0] winner_score,
   output logic [SCORE_W-1:0] margin,
   output logic               seq_err
);

   logic [1:0]         state;
   logic [IDX_W-1:0]   cnt;
   logic [SCORE_W-1:0] best;
   logic [SCORE_W-1:0] second;
   logic [IDX_W-1:0]   best_idx;
   logic [SCORE_W-1:0] best_nxt;
   logic [SCORE_W-1:0] second_nxt;
   logic [IDX_W-1:0]   best_idx_nxt;
   logic               last_score;

   assoc_top2_tracker #(
      .SCORE_W (SCORE_W),
      .IDX_W   (IDX_W)
   ) u_tracker (
      .score_in     (score_in),
      .cnt          (cnt),
      .best         (best),
      .second       (second),
      .best_idx     (best_idx),
      .best_nxt     (best_nxt),
      .second_nxt   (second_nxt),
      .best_idx_nxt (best_idx_nxt)
   );

   assign last_score = (cnt == IDX_W'(NUM_CLASSES - 1));
   assign busy       = (state == COLLECT);
   assign done       = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         best         <= '0;
         second       <= '0;
         best_idx     <= '0;
         winner_idx   <= '0;
         winner_score <= '0;
         margin       <= '0;
         seq_err      <= 1'b0;
      end else if (start) begin
         // start wins over a coincident score, which is dropped
         state    <= COLLECT;
         cnt      <= '0;
         best     <= '0;
         second   <= '0;
         best_idx <= '0;
         seq_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (score_valid) seq_err <= 1'b1;
            end
            COLLECT: begin
               if (score_valid) begin
                  best     <= best_nxt;
                  second   <= second_nxt;
                  best_idx <= best_idx_nxt;
                  if (last_score) begin
                     state        <= DONE;
                     winner_idx   <= best_idx_nxt;
                     winner_score <= best_nxt;
                     margin       <= best_nxt - second_nxt;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               if (score_valid) seq_err <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_assoc_argmax.sv
// Scoreboard bench for assoc_argmax with 4 classes: directed cases plus
// randomized queries checked against a sort-style top-2 reference.
module tb_assoc_argmax;
   localparam int NC = 4;
   localparam int SW = 13;
   localparam int IW = 5;

   typedef struct {
      int idx;
      int score;
      int margin;
   } res_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          score_valid = 1'b0;
   logic [SW-1:0] score_in = '0;
   logic          busy, done, seq_err;
   logic [IW-1:0] winner_idx;
   logic [SW-1:0] winner_score, margin;

   int   checks = 0;
   int   errors = 0;
   int   busy_cnt = 0;
   int   done_cnt = 0;
   int   exp_dones = 0;
   res_t expq[$];
   res_t last_pub = '{0, 0, 0};

   assoc_argmax #(.SCORE_W(SW), .NUM_CLASSES(NC), .IDX_W(IW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .score_valid  (score_valid),
      .score_in     (score_in),
      .busy         (busy),
      .done         (done),
      .winner_idx   (winner_idx),
      .winner_score (winner_score),
      .margin       (margin),
      .seq_err      (seq_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: winner is the first occurrence of the maximum; runner-up is
   // the largest of the remaining scores (duplicates of the max count).
   function automatic res_t model(input int sc[NC]);
      res_t r;
      int   bi = 0;
      int   sec = 0;
      for (int i = 1; i < NC; i++)
         if (sc[i] > sc[bi]) bi = i;
      for (int j = 0; j < NC; j++)
         if (j != bi && sc[j] > sec) sec = sc[j];
      r.idx = bi;
      r.score = sc[bi];
      r.margin = sc[bi] - sec;
      return r;
   endfunction

   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (done) begin
         done_cnt++;
         if (expq.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            res_t e;
            e = expq.pop_front();
            check("winner_idx", 32'(winner_idx), 32'(e.idx));
            check("winner_score", 32'(winner_score), 32'(e.score));
            check("margin", 32'(margin), 32'(e.margin));
            last_pub = e;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input int s, input int gap);
      score_valid = 1'b0;
      repeat (gap) tick();
      score_valid = 1'b1;
      score_in = SW'(s);
      tick();
      score_valid = 1'b0;
   endtask

   task automatic check_held(input string name);
      check({name, "_idx"}, 32'(winner_idx), 32'(last_pub.idx));
      check({name, "_score"}, 32'(winner_score), 32'(last_pub.score));
      check({name, "_margin"}, 32'(margin), 32'(last_pub.margin));
   endtask

   // Assumes start was just issued; feeds all NC scores and checks timing.
   task automatic collect(input int sc[NC], input int gap[NC], input bit stray_in_done);
      int total = NC;
      busy_cnt = 0;
      for (int i = 0; i < NC; i++) begin
         total += gap[i];
         if (i == NC - 1) begin
            expq.push_back(model(sc));
            exp_dones++;
         end
         feed(sc[i], gap[i]);
         if (i < NC - 1) check("no_early_done", 32'(done), 32'd0);
      end
      check("done_latency", 32'(done), 32'd1);
      check("busy_cycles", 32'(busy_cnt), 32'(total));
      if (stray_in_done) begin
         score_valid = 1'b1;
         score_in = SW'(123);
      end
      tick();
      score_valid = 1'b0;
      check("done_pulse_end", 32'(done), 32'd0);
      check("seq_err_done", 32'(seq_err), 32'(stray_in_done));
   endtask

   task automatic run_query(input int sc[NC], input int gap[NC], input bit stray_in_done);
      do_start();
      check("seq_err_cleared", 32'(seq_err), 32'd0);
      check("busy_after_start", 32'(busy), 32'd1);
      collect(sc, gap, stray_in_done);
   endtask

   initial begin
      int z[NC] = '{0, 0, 0, 0};
      int sc[NC];
      int gp[NC];

      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_seq_err", 32'(seq_err), 32'd0);
      check_held("rst");
      rst = 1'b0;
      tick();

      run_query('{100, 250, 30, 200}, z, 1'b0);
      run_query('{300, 300, 10, 0}, z, 1'b0);
      run_query('{5, 8191, 7, 8190}, '{0, 2, 1, 0}, 1'b0);
      run_query('{0, 0, 0, 0}, z, 1'b0);

      // abort mid-query: only the second query publishes
      do_start();
      feed(900, 0);
      feed(900, 0);
      do_start();
      collect('{1, 2, 3, 4}, z, 1'b0);

      // stray score in IDLE
      score_valid = 1'b1;
      score_in = SW'(77);
      tick();
      score_valid = 1'b0;
      check("stray_seq_err", 32'(seq_err), 32'd1);
      check("stray_done", 32'(done), 32'd0);
      check_held("stray_hold");
      repeat (2) tick();
      check("seq_err_sticky", 32'(seq_err), 32'd1);

      // start with a coincident score: the score must be dropped
      start = 1'b1;
      score_valid = 1'b1;
      score_in = SW'(8000);
      tick();
      start = 1'b0;
      score_valid = 1'b0;
      check("start_clears_seq_err", 32'(seq_err), 32'd0);
      collect('{10, 20, 15, 5}, z, 1'b0);

      // back-to-back: start during the DONE cycle
      do_start();
      for (int i = 0; i < NC; i++) begin
         if (i == NC - 1) begin
            expq.push_back(model('{40, 50, 60, 70}));
            exp_dones++;
         end
         feed(40 + 10 * i, 0);
      end
      check("b2b_done", 32'(done), 32'd1);
      do_start();
      check("b2b_busy", 32'(busy), 32'd1);
      collect('{7, 6, 5, 4}, z, 1'b0);

      // reset mid-collect clears everything including published outputs
      do_start();
      feed(500, 0);
      feed(600, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_pub = '{0, 0, 0};
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_seq_err", 32'(seq_err), 32'd0);
      check_held("midrst");
      run_query('{9, 3, 9, 1}, z, 1'b0);

      for (int q = 0; q < 30; q++) begin
         for (int i = 0; i < NC; i++) begin
            if (q % 3 == 0) sc[i] = int'($urandom_range(0, 3)) * 2000;
            else sc[i] = int'($urandom_range(0, 8191));
            gp[i] = int'($urandom_range(0, 2));
         end
         run_query(sc, gp, q % 4 == 1);
         repeat ($urandom_range(0, 2)) tick();
         check_held("rand_hold");
      end

      repeat (3) tick();
      check("pending_results", 32'(expq.size()), 32'd0);
      check("done_count", 32'(done_cnt), 32'(exp_dones));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end
endmodule
